// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events,
// one pending slot per button, drained round-robin over a valid/ready port.
module button_event_ctrl #(
   parameter int WIDTH        = 4,
   parameter int TICK_DIV     = 50000,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 100,
   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic            clk,
   input  logic            anrst,
   input  logic            ena,
   input  logic [WIDTH-1:0] btn,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [IDXW-1:0] ev_idx,
   output logic [1:0]      ev_type,
   output logic            ovf,
   input  logic            ovf_clr
);

   localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ?
                         LONG_TICKS : REPEAT_TICKS;
   localparam int CNTW = $clog2(MAXT + 1);
   localparam int TDW  = $clog2(TICK_DIV);
   localparam int REPM = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

   localparam logic [CNTW-1:0] LONG_LAST = CNTW'(LONG_TICKS - 1);
   localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPM);
   localparam logic [TDW-1:0]  TICK_LAST = TDW'(TICK_DIV - 1);
   localparam logic [IDXW-1:0] PTR_RST   = IDXW'(WIDTH - 1);

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_RELEASE = 2'd1;
   localparam logic [1:0] EV_LONG    = 2'd2;
   localparam logic [1:0] EV_REPEAT  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_HELD
   } state_t;

   logic [TDW-1:0]   r_tcnt;
   logic             w_tick;
   logic [WIDTH-1:0] r_btn_prev;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   state_t           r_st [WIDTH];
   logic [CNTW-1:0]  r_cnt [WIDTH];
   logic [WIDTH-1:0] w_ev;
   logic [1:0]       w_ev_type [WIDTH];
   logic [WIDTH-1:0] r_pend;
   logic [1:0]       r_ptype [WIDTH];
   logic [IDXW-1:0]  r_ptr;
   logic [IDXW-1:0]  w_gnt_idx;
   logic [1:0]       w_gnt_type;
   logic             w_gnt_any;
   logic             w_load;
   logic [WIDTH-1:0] w_gnt;
   logic             w_ovf_set;

   assign w_tick = ena && (r_tcnt == TICK_LAST);
   assign w_rise = btn & ~r_btn_prev;
   assign w_fall = ~btn & r_btn_prev;

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         r_tcnt     <= '0;
         r_btn_prev <= '0;
      end else begin
         r_btn_prev <= btn;
         if (!ena || w_tick) r_tcnt <= '0;
         else                r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // A fall always beats a coincident tick so RELEASE is never lost.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_ev[i]      = 1'b0;
         w_ev_type[i] = EV_PRESS;
         if (ena) begin
            case (r_st[i])
               S_IDLE: begin
                  if (w_rise[i]) w_ev[i] = 1'b1;
               end
               S_PRESSED: begin
                  if (w_fall[i]) begin
                     w_ev[i]      = 1'b1;
                     w_ev_type[i] = EV_RELEASE;
                  end else if (w_tick && r_cnt[i] == LONG_LAST) begin
                     w_ev[i]      = 1'b1;
                     w_ev_type[i] = EV_LONG;
                  end
               end
               S_HELD: begin
                  if (w_fall[i]) begin
                     w_ev[i]      = 1'b1;
                     w_ev_type[i] = EV_RELEASE;
                  end else if (REPEAT_TICKS > 0 && w_tick &&
                               r_cnt[i] == REP_LAST) begin
                     w_ev[i]      = 1'b1;
                     w_ev_type[i] = EV_REPEAT;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_st[i]  <= S_IDLE;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!ena) begin
               r_st[i]  <= S_IDLE;
               r_cnt[i] <= '0;
            end else begin
               case (r_st[i])
                  S_IDLE: begin
                     if (w_rise[i]) begin
                        r_st[i]  <= S_PRESSED;
                        r_cnt[i] <= '0;
                     end
                  end
                  S_PRESSED: begin
                     if (w_fall[i]) begin
                        r_st[i] <= S_IDLE;
                     end else if (w_tick) begin
                        if (r_cnt[i] == LONG_LAST) begin
                           r_st[i]  <= S_HELD;
                           r_cnt[i] <= '0;
                        end else begin
                           r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                     end
                  end
                  S_HELD: begin
                     if (w_fall[i]) begin
                        r_st[i] <= S_IDLE;
                     end else if (REPEAT_TICKS > 0 && w_tick) begin
                        if (r_cnt[i] == REP_LAST) r_cnt[i] <= '0;
                        else r_cnt[i] <= r_cnt[i] + 1'b1;
                     end
                  end
                  default: r_st[i] <= S_IDLE;
               endcase
            end
         end
      end
   end

   // Search above the pointer first, then wrap to the low indices.
   always_comb begin
      w_gnt_any  = 1'b0;
      w_gnt_idx  = '0;
      w_gnt_type = EV_PRESS;
      for (int j = 0; j < WIDTH; j++) begin
         if (!w_gnt_any && r_pend[j] && j > int'(r_ptr)) begin
            w_gnt_any  = 1'b1;
            w_gnt_idx  = IDXW'(j);
            w_gnt_type = r_ptype[j];
         end
      end
      for (int j = 0; j < WIDTH; j++) begin
         if (!w_gnt_any && r_pend[j] && j <= int'(r_ptr)) begin
            w_gnt_any  = 1'b1;
            w_gnt_idx  = IDXW'(j);
            w_gnt_type = r_ptype[j];
         end
      end
   end

   assign w_load = (~ev_valid | ev_ready) & w_gnt_any;

   always_comb begin
      w_gnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_gnt[i] = w_load && (w_gnt_idx == IDXW'(i));
      end
   end

   assign w_ovf_set = |(w_ev & r_pend & ~w_gnt);

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         r_pend <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) r_ptype[i] <= EV_PRESS;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_ev[i]) begin
               r_pend[i]  <= 1'b1;
               r_ptype[i] <= w_ev_type[i];
            end else if (w_gnt[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
         if (w_ovf_set)    ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         ev_valid <= 1'b0;
         ev_idx   <= '0;
         ev_type  <= EV_PRESS;
         r_ptr    <= PTR_RST;
      end else if (w_load) begin
         ev_valid <= 1'b1;
         ev_idx   <= w_gnt_idx;
         ev_type  <= w_gnt_type;
         r_ptr    <= w_gnt_idx;
      end else if (ev_ready) begin
         ev_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus queues expected events
// with their handshake cycle, a negedge monitor pops and compares them.
module tb_button_event_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         anrst = 1'b0;
   logic         ena = 1'b0;
   logic         ev_ready = 1'b0;
   logic         ovf_clr = 1'b0;
   logic [W-1:0] btn = '0;
   logic         ev_valid;
   logic         ovf;
   logic [1:0]   ev_idx;
   logic [1:0]   ev_type;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int R = 0;
   int E = 0;
   int X = 0;

   typedef struct {
      int idx;
      int typ;
      int cyc;
   } exp_t;

   exp_t q[$];
   exp_t m_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_event_ctrl #(
      .WIDTH(W),
      .TICK_DIV(4),
      .LONG_TICKS(3),
      .REPEAT_TICKS(2)
   ) dut (
      .clk(clk),
      .anrst(anrst),
      .ena(ena),
      .btn(btn),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_idx(ev_idx),
      .ev_type(ev_type),
      .ovf(ovf),
      .ovf_clr(ovf_clr)
   );

   function automatic void check(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    name, act, exp, cyc);
   endfunction

   task automatic push(int idx, int typ, int c);
      exp_t e;
      e.idx = idx;
      e.typ = typ;
      e.cyc = c;
      q.push_back(e);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at(int c);
      while (cyc < c) step(1);
   endtask

   always @(negedge clk) begin
      if (anrst && ev_valid && ev_ready) begin
         if (q.size() == 0) begin
            check("spurious_ev_type", int'(ev_type), -1);
         end else begin
            m_e = q.pop_front();
            check("ev_idx", int'(ev_idx), m_e.idx);
            check("ev_type", int'(ev_type), m_e.typ);
            check("ev_cycle", cyc, m_e.cyc);
         end
      end
   end

   initial begin
      anrst = 1'b0;
      ena = 1'b1;
      ev_ready = 1'b1;
      step(3);
      check("rst_valid", int'(ev_valid), 0);
      check("rst_idx", int'(ev_idx), 0);
      check("rst_type", int'(ev_type), 0);
      check("rst_ovf", int'(ovf), 0);
      anrst = 1'b1;
      R = cyc;
      step(2);

      // all four at once, pointer at 3 after reset
      E = cyc;
      btn = 4'hF;
      for (int k = 0; k < 4; k++) push(k, 0, E + 2 + k);
      for (int k = 0; k < 4; k++) push(k, 1, E + 8 + k);
      at(E + 6);
      btn = '0;
      at(E + 14);

      // short press on button 2
      E = cyc;
      btn[2] = 1'b1;
      push(2, 0, E + 2);
      push(2, 1, E + 7);
      at(E + 5);
      btn[2] = 1'b0;
      at(E + 10);

      // tap button 1 to leave the pointer at 1
      E = cyc;
      btn[1] = 1'b1;
      push(1, 0, E + 2);
      push(1, 1, E + 4);
      at(E + 2);
      btn[1] = 1'b0;
      at(E + 8);

      E = cyc;
      btn = 4'hF;
      push(2, 0, E + 2);
      push(3, 0, E + 3);
      push(0, 0, E + 4);
      push(1, 0, E + 5);
      at(E + 6);
      btn = '0;
      push(2, 1, E + 8);
      push(3, 1, E + 9);
      push(0, 1, E + 10);
      push(1, 1, E + 11);
      at(E + 14);

      // long hold, started on a tick-aligned cycle
      while (((cyc - R) % 4) != 0) step(1);
      E = cyc;
      btn[0] = 1'b1;
      push(0, 0, E + 2);
      push(0, 2, E + 13);
      push(0, 3, E + 21);
      push(0, 3, E + 29);
      push(0, 3, E + 37);
      push(0, 1, E + 42);
      at(E + 40);
      btn[0] = 1'b0;
      at(E + 46);

      // backpressure and overwrite
      E = cyc;
      ev_ready = 1'b0;
      btn[0] = 1'b1;
      at(E + 2);
      btn[1] = 1'b1;
      check("bp_valid", int'(ev_valid), 1);
      check("bp_idx", int'(ev_idx), 0);
      check("bp_type", int'(ev_type), 0);
      for (int c = 3; c <= 5; c++) begin
         at(E + c);
         check("bp_hold_valid", int'(ev_valid), 1);
         check("bp_hold_idx", int'(ev_idx), 0);
         check("bp_hold_type", int'(ev_type), 0);
         check("bp_ovf_low", int'(ovf), 0);
      end
      btn[1] = 1'b0;
      at(E + 6);
      check("bp_ovf_set", int'(ovf), 1);
      check("bp_hold_idx6", int'(ev_idx), 0);
      ovf_clr = 1'b1;
      at(E + 7);
      check("bp_ovf_clr", int'(ovf), 0);
      check("bp_hold_valid7", int'(ev_valid), 1);
      ovf_clr = 1'b0;
      btn[0] = 1'b0;
      at(E + 8);
      ev_ready = 1'b1;
      push(0, 0, E + 8);
      push(1, 1, E + 9);
      push(0, 1, E + 10);
      at(E + 13);

      // asynchronous reset while button 3 is held with LONG stalled
      E = cyc;
      btn[3] = 1'b1;
      push(3, 0, E + 2);
      at(E + 3);
      ev_ready = 1'b0;
      at(E + 16);
      check("held_valid", int'(ev_valid), 1);
      check("held_idx", int'(ev_idx), 3);
      check("held_type", int'(ev_type), 2);
      #2;
      anrst = 1'b0;
      #1;
      check("arst_valid", int'(ev_valid), 0);
      check("arst_idx", int'(ev_idx), 0);
      check("arst_type", int'(ev_type), 0);
      check("arst_ovf", int'(ovf), 0);
      @(posedge clk);
      #1;
      anrst = 1'b1;
      ev_ready = 1'b1;
      X = cyc;
      push(3, 0, X + 2);
      at(X + 4);
      btn[3] = 1'b0;
      push(3, 1, X + 6);
      at(X + 10);

      // disable during a hold: no LONG/REPEAT/RELEASE
      E = cyc;
      btn[2] = 1'b1;
      push(2, 0, E + 2);
      at(E + 3);
      ena = 1'b0;
      at(E + 20);
      check("dis_valid_a", int'(ev_valid), 0);
      at(E + 33);
      check("dis_valid_b", int'(ev_valid), 0);
      ena = 1'b1;
      at(E + 53);
      btn[2] = 1'b0;
      at(E + 60);
      check("dis_valid_c", int'(ev_valid), 0);
      E = cyc;
      btn[2] = 1'b1;
      push(2, 0, E + 2);
      at(E + 3);
      btn[2] = 1'b0;
      push(2, 1, E + 5);
      at(E + 10);

      for (int k = 0; k < 50 && q.size() != 0; k++) step(1);
      check("scoreboard_left", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
